// File: rtl/ecall_io_unit.sv
// ecall_io_unit: ecall I/O controller for the single-cycle RISC-V core.
//
// Serves ecall requests from the decoder:
//   op 00 read switches : stall the PC until a debounced press+release of
//                         continue_button, then return the switches captured
//                         at the press for one cycle (io_rvalid)
//   op 01 write hex     : show io_wdata on the display in hex
//   op 10 write decimal : show io_wdata as a signed decimal number (iterative
//                         double-dabble, DATA_W cycles, display updates atomically)
//   op 11 write LEDs    : led <= io_wdata[LED_W-1:0]
//
// Ports:
//   clock, reset               rising-edge clock, asynchronous active-low reset
//   io_req, io_op, io_wdata    request from the decoder (held while stall=1)
//   switches, continue_button  raw board inputs
//   stall                      combinational PC / writeback freeze
//   io_rvalid, io_rdata        read completion strobe and zero-extended data
//   led                        LED register
//   segment_output             active-high segments {g,f,e,d,c,b,a}
//   digit_select_output        one-hot, active-high digit enable
module ecall_io_unit #(
  parameter int DATA_W       = 32,
  parameter int SW_W         = 8,
  parameter int LED_W        = 8,
  parameter int DIGITS       = 8,
  parameter int DEBOUNCE_CYC = 1000000,
  parameter int SCAN_DIV     = 100000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                io_req,
  input  logic [1:0]          io_op,
  input  logic [DATA_W-1:0]   io_wdata,
  input  logic [SW_W-1:0]     switches,
  input  logic                continue_button,
  output logic                stall,
  output logic                io_rvalid,
  output logic [DATA_W-1:0]   io_rdata,
  output logic [LED_W-1:0]    led,
  output logic [6:0]          segment_output,
  output logic [DIGITS-1:0]   digit_select_output
);

  // Largest magnitude that fits in the DIGITS-1 numeric digits.
  function automatic longint unsigned pow10_m1(input int n);
    longint unsigned p;
    p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p - 1;
  endfunction

  localparam int DB_W   = $clog2(DEBOUNCE_CYC + 1);
  localparam int SCAN_W = $clog2(SCAN_DIV + 1);
  localparam int IDX_W  = $clog2(DIGITS);
  localparam int CNT_W  = $clog2(DATA_W + 1);
  localparam int BCD_W  = (DIGITS - 1) * 4;
  localparam int DISP_W = DIGITS * 4;
  localparam logic [DATA_W-1:0] MAX_MAG = DATA_W'(pow10_m1(DIGITS - 1));

  localparam logic [6:0] GLYPH_DASH  = 7'h40;
  localparam logic [6:0] GLYPH_BLANK = 7'h00;

  typedef enum logic [1:0] {
    OP_READ = 2'b00,
    OP_HEX  = 2'b01,
    OP_DEC  = 2'b10,
    OP_LED  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_PRESS,
    ST_WAIT_RELEASE,
    ST_DONE
  } state_e;

  function automatic logic [6:0] hex_glyph(input logic [3:0] n);
    logic [6:0] g;
    case (n)
      4'h0: g = 7'h3F;  4'h1: g = 7'h06;  4'h2: g = 7'h5B;  4'h3: g = 7'h4F;
      4'h4: g = 7'h66;  4'h5: g = 7'h6D;  4'h6: g = 7'h7D;  4'h7: g = 7'h07;
      4'h8: g = 7'h7F;  4'h9: g = 7'h6F;  4'hA: g = 7'h77;  4'hB: g = 7'h7C;
      4'hC: g = 7'h39;  4'hD: g = 7'h5E;  4'hE: g = 7'h79;  default: g = 7'h71;
    endcase
    return g;
  endfunction

  // ---------------------------------------------------------------------
  // Button: 2-FF synchroniser, debounce counter, rising-edge press pulse
  // ---------------------------------------------------------------------
  logic            btn_sync1, btn_sync2;
  logic            deb_level;
  logic [DB_W-1:0] deb_cnt;
  logic            press;

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      btn_sync1 <= 1'b0;
      btn_sync2 <= 1'b0;
      deb_level <= 1'b0;
      deb_cnt   <= '0;
      press     <= 1'b0;
    end else begin
      btn_sync1 <= continue_button;
      btn_sync2 <= btn_sync1;
      press     <= 1'b0;
      if (btn_sync2 != deb_level) begin
        if (deb_cnt == DB_W'(DEBOUNCE_CYC - 1)) begin
          deb_level <= btn_sync2;
          deb_cnt   <= '0;
          press     <= btn_sync2;
        end else begin
          deb_cnt <= deb_cnt + DB_W'(1);
        end
      end else begin
        deb_cnt <= '0;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Read request FSM
  // ---------------------------------------------------------------------
  state_e          state_q, state_d;
  logic            capture;
  logic [SW_W-1:0] rdata_q;
  logic            is_read, is_hex, is_dec, is_led;
  logic            conv_busy;

  assign is_read = io_req && (io_op == OP_READ);
  assign is_hex  = io_req && (io_op == OP_HEX);
  assign is_dec  = io_req && (io_op == OP_DEC);
  assign is_led  = io_req && (io_op == OP_LED);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (capture) rdata_q <= switches;
    end
  end

  // NOTE: every signal driven here gets a default first so no path through
  // the case leaves it unassigned (which would infer a latch).
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    unique case (state_q)
      ST_IDLE:         if (is_read) state_d = ST_WAIT_PRESS;
      ST_WAIT_PRESS:   if (press) begin
                         capture = 1'b1;
                         state_d = ST_WAIT_RELEASE;
                       end
      ST_WAIT_RELEASE: if (!deb_level) state_d = ST_DONE;
      ST_DONE:         state_d = ST_IDLE;
      default:         state_d = ST_IDLE;
    endcase
  end

  // Gated by reset so the CPU is released immediately on an abort.
  assign stall = reset && ((is_read && (state_q != ST_DONE)) ||
                           (is_dec && conv_busy));
  assign io_rvalid = (state_q == ST_DONE);
  assign io_rdata  = DATA_W'(rdata_q);

  // ---------------------------------------------------------------------
  // LED register
  // ---------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)      led <= '0;
    else if (is_led) led <= io_wdata[LED_W-1:0];
  end

  // ---------------------------------------------------------------------
  // Double-dabble converter: DATA_W shift steps, then one commit cycle
  // ---------------------------------------------------------------------
  logic              dec_go;
  logic [DATA_W-1:0] mag;
  logic [CNT_W-1:0]  conv_cnt;
  logic [DATA_W-1:0] conv_sh;
  logic [BCD_W-1:0]  conv_bcd, bcd_adj;
  logic              conv_neg, conv_ovf;
  logic              conv_done;

  assign dec_go    = is_dec && !conv_busy;
  assign mag       = io_wdata[DATA_W-1] ? (~io_wdata + DATA_W'(1)) : io_wdata;
  assign conv_done = conv_busy && (conv_cnt == CNT_W'(DATA_W));

  // Digits that would overflow on doubling get +3 before the shift. BCD
  // bits shifted out of the top are only non-zero when the value is out of
  // range, which is flagged separately by conv_ovf.
  always_comb begin
    bcd_adj = conv_bcd;
    for (int i = 0; i < DIGITS - 1; i++) begin
      if (conv_bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = conv_bcd[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      conv_busy <= 1'b0;
      conv_cnt  <= '0;
      conv_sh   <= '0;
      conv_bcd  <= '0;
      conv_neg  <= 1'b0;
      conv_ovf  <= 1'b0;
    end else if (dec_go) begin
      conv_busy <= 1'b1;
      conv_cnt  <= '0;
      conv_sh   <= mag;
      conv_bcd  <= '0;
      conv_neg  <= io_wdata[DATA_W-1];
      conv_ovf  <= (mag > MAX_MAG);
    end else if (conv_busy) begin
      if (conv_done) begin
        conv_busy <= 1'b0;
      end else begin
        conv_bcd <= {bcd_adj[BCD_W-2:0], conv_sh[DATA_W-1]};
        conv_sh  <= {conv_sh[DATA_W-2:0], 1'b0};
        conv_cnt <= conv_cnt + CNT_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------
  // Display content; a finishing conversion wins over a same-edge hex write
  // ---------------------------------------------------------------------
  logic [DISP_W-1:0] disp_value;
  logic              disp_hex, disp_neg, disp_ovf;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      disp_value <= '0;
      disp_hex   <= 1'b1;
      disp_neg   <= 1'b0;
      disp_ovf   <= 1'b0;
    end else if (conv_done) begin
      disp_value <= {4'h0, conv_bcd};
      disp_hex   <= 1'b0;
      disp_neg   <= conv_neg;
      disp_ovf   <= conv_ovf;
    end else if (is_hex) begin
      disp_value <= io_wdata[DISP_W-1:0];
      disp_hex   <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Digit scan and glyph selection
  // ---------------------------------------------------------------------
  logic [SCAN_W-1:0] scan_cnt;
  logic [IDX_W-1:0]  digit_idx;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      scan_cnt  <= '0;
      digit_idx <= '0;
    end else if (scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
      scan_cnt  <= '0;
      digit_idx <= (digit_idx == IDX_W'(DIGITS - 1)) ? '0 : digit_idx + IDX_W'(1);
    end else begin
      scan_cnt <= scan_cnt + SCAN_W'(1);
    end
  end

  // Leading-zero blanking: a numeric digit is blank when it and every
  // numeric digit above it are zero; digit 0 is always lit.
  logic [DIGITS-1:0] blank;
  logic              seen_nz;

  always_comb begin
    blank   = '0;
    seen_nz = 1'b0;
    for (int i = DIGITS - 2; i >= 0; i--) begin
      if (disp_value[4*i +: 4] != 4'h0) seen_nz = 1'b1;
      blank[i] = !seen_nz && (i != 0);
    end
  end

  logic [3:0] cur_nib;
  assign cur_nib = disp_value[{digit_idx, 2'b00} +: 4];

  always_comb begin
    segment_output = hex_glyph(cur_nib);
    if (!disp_hex) begin
      if (disp_ovf)                                segment_output = GLYPH_DASH;
      else if (digit_idx == IDX_W'(DIGITS - 1))    segment_output = disp_neg ? GLYPH_DASH : GLYPH_BLANK;
      else if (blank[digit_idx])                   segment_output = GLYPH_BLANK;
    end
  end

  assign digit_select_output = DIGITS'(1) << digit_idx;

endmodule

// File: tb/tb_ecall_io_unit.sv
// Directed testbench for ecall_io_unit with DEBOUNCE_CYC=4, SCAN_DIV=2.
module tb_ecall_io_unit;

  localparam int DATA_W = 32;
  localparam int DIGITS = 8;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              io_req = 1'b0;
  logic [1:0]        io_op = 2'b00;
  logic [DATA_W-1:0] io_wdata = '0;
  logic [7:0]        switches = '0;
  logic              continue_button = 1'b0;
  logic              stall, io_rvalid;
  logic [DATA_W-1:0] io_rdata;
  logic [7:0]        led;
  logic [6:0]        segment_output;
  logic [DIGITS-1:0] digit_select_output;

  int n_cmp = 0;
  int n_err = 0;

  // Expected glyphs, index = digit number.
  logic [6:0] exp_beef  [8] = '{7'h71, 7'h79, 7'h79, 7'h7C, 7'h5E, 7'h77, 7'h79, 7'h5E};
  logic [6:0] exp_m1234 [8] = '{7'h66, 7'h4F, 7'h5B, 7'h06, 7'h00, 7'h00, 7'h00, 7'h40};

  ecall_io_unit #(
    .DATA_W(DATA_W), .SW_W(8), .LED_W(8), .DIGITS(DIGITS),
    .DEBOUNCE_CYC(4), .SCAN_DIV(2)
  ) dut (
    .clock(clock), .reset(reset), .io_req(io_req), .io_op(io_op),
    .io_wdata(io_wdata), .switches(switches), .continue_button(continue_button),
    .stall(stall), .io_rvalid(io_rvalid), .io_rdata(io_rdata), .led(led),
    .segment_output(segment_output), .digit_select_output(digit_select_output)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Wait (bounded) until digit k is selected and return its segments; 'x on timeout.
  task automatic get_seg(input int k, output logic [6:0] s);
    logic [DIGITS-1:0] want;
    bit found;
    want  = DIGITS'(1) << k;
    found = 0;
    s     = 'x;
    for (int c = 0; c < 40 && !found; c++) begin
      if (digit_select_output === want) begin
        s = segment_output;
        found = 1;
      end else begin
        tick(1);
      end
    end
  endtask

  function automatic int cur_idx();
    int r;
    r = -1;
    for (int k = 0; k < DIGITS; k++)
      if (digit_select_output === (DIGITS'(1) << k)) r = k;
    return r;
  endfunction

  task automatic test_reset();
    io_req = 1'b1; io_op = 2'b00;
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b expected 0", stall); end
    io_req = 1'b0;
    #1;
    n_cmp++; if (digit_select_output !== 8'h01) begin n_err++; $display("FAIL reset_sel: got %h expected 01", digit_select_output); end
    n_cmp++; if (segment_output !== 7'h3F) begin n_err++; $display("FAIL reset_seg: got %h expected 3f", segment_output); end
    n_cmp++; if (led !== 8'h00) begin n_err++; $display("FAIL reset_led: got %h expected 00", led); end
    n_cmp++; if (io_rvalid !== 1'b0) begin n_err++; $display("FAIL reset_rvalid: got %b expected 0", io_rvalid); end
    n_cmp++; if (io_rdata !== 32'h0) begin n_err++; $display("FAIL reset_rdata: got %h expected 0", io_rdata); end
    tick(2);
    reset = 1'b1;
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL idle_stall: got %b expected 0", stall); end
    for (int k = 0; k < 9; k++) begin
      n_cmp++;
      if (digit_select_output !== (8'h01 << (k % 8))) begin
        n_err++; $display("FAIL scan_step%0d: got %h expected %h", k, digit_select_output, 8'h01 << (k % 8));
      end
      tick(2);
    end
  endtask

  task automatic test_read();
    int seen;
    switches = 8'hA5;
    io_req = 1'b1; io_op = 2'b00;
    #1;
    n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL read_stall_start: got %b expected 1", stall); end
    tick(2);
    continue_button = 1'b1; tick(3); continue_button = 1'b0;
    seen = 0;
    for (int c = 0; c < 10; c++) begin if (io_rvalid === 1'b1) seen++; tick(1); end
    n_cmp++; if (seen !== 0) begin n_err++; $display("FAIL glitch_rvalid: got %0d expected 0", seen); end
    n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL glitch_stall: got %b expected 1", stall); end
    continue_button = 1'b1;
    for (int c = 0; c < 12; c++) begin if (io_rvalid === 1'b1) seen++; tick(1); end
    n_cmp++; if (stall !== 1'b1 || seen !== 0) begin n_err++; $display("FAIL held_press_stall: got stall=%b rv=%0d expected 1/0", stall, seen); end
    switches = 8'h00;  // capture happened at the press
    continue_button = 1'b0;
    for (int c = 0; c < 30 && io_rvalid !== 1'b1; c++) tick(1);
    n_cmp++; if (io_rvalid !== 1'b1) begin n_err++; $display("FAIL read_done: got %b expected 1", io_rvalid); end
    n_cmp++; if (io_rdata !== 32'h000000A5) begin n_err++; $display("FAIL read_rdata: got %h expected 000000a5", io_rdata); end
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL read_done_stall: got %b expected 0", stall); end
    io_req = 1'b0;
    tick(1);
    n_cmp++; if (io_rvalid !== 1'b0) begin n_err++; $display("FAIL read_one_cycle: got %b expected 0", io_rvalid); end
  endtask

  task automatic test_held_button();
    int seen;
    continue_button = 1'b1;
    tick(12);
    switches = 8'h3C;
    io_req = 1'b1; io_op = 2'b00;
    seen = 0;
    for (int c = 0; c < 20; c++) begin tick(1); if (io_rvalid === 1'b1) seen++; end
    continue_button = 1'b0;
    for (int c = 0; c < 12; c++) begin tick(1); if (io_rvalid === 1'b1) seen++; end
    n_cmp++; if (seen !== 0) begin n_err++; $display("FAIL held_no_read: got %0d expected 0", seen); end
    n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL held_stall: got %b expected 1", stall); end
    continue_button = 1'b1; tick(12); continue_button = 1'b0;
    for (int c = 0; c < 30 && io_rvalid !== 1'b1; c++) tick(1);
    n_cmp++; if (io_rvalid !== 1'b1 || io_rdata !== 32'h3C) begin
      n_err++; $display("FAIL held_read: got rv=%b data=%h expected 1/0000003c", io_rvalid, io_rdata);
    end
    io_req = 1'b0;
    tick(1);
  endtask

  task automatic test_hex_led();
    logic [6:0] s;
    io_req = 1'b1; io_op = 2'b01; io_wdata = 32'hDEADBEEF;
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL hex_stall: got %b expected 0", stall); end
    tick(1);
    io_op = 2'b11; io_wdata = 32'h000001FF;
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL led_stall: got %b expected 0", stall); end
    tick(1);
    io_req = 1'b0;
    n_cmp++; if (led !== 8'hFF) begin n_err++; $display("FAIL led_value: got %h expected ff", led); end
    for (int k = 0; k < 8; k++) begin
      get_seg(k, s);
      n_cmp++; if (s !== exp_beef[k]) begin n_err++; $display("FAIL hex_digit%0d: got %h expected %h", k, s, exp_beef[k]); end
    end
  endtask

  task automatic test_decimal();
    logic [6:0] s;
    int k;
    io_req = 1'b1; io_op = 2'b10; io_wdata = -32'sd1234;
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL dec_accept_stall: got %b expected 0", stall); end
    tick(1);            // acceptance edge
    io_req = 1'b0;
    tick(32);           // 32 edges after acceptance: old hex content still shown
    k = cur_idx();
    n_cmp++; if (k < 0 || segment_output !== exp_beef[k & 7]) begin
      n_err++; $display("FAIL dec_before_commit: got %h expected %h", segment_output, exp_beef[k & 7]);
    end
    tick(1);            // 33rd edge: new content
    k = cur_idx();
    n_cmp++; if (k < 0 || segment_output !== exp_m1234[k & 7]) begin
      n_err++; $display("FAIL dec_at_commit: got %h expected %h", segment_output, exp_m1234[k & 7]);
    end
    for (int d = 0; d < 8; d++) begin
      get_seg(d, s);
      n_cmp++; if (s !== exp_m1234[d]) begin n_err++; $display("FAIL dec_digit%0d: got %h expected %h", d, s, exp_m1234[d]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] s;
    int stall_cycles;
    io_req = 1'b1; io_op = 2'b10; io_wdata = 32'd42;
    tick(1);            // first accepted
    io_req = 1'b0;
    tick(5);
    io_req = 1'b1; io_wdata = 32'd7;
    #1;
    stall_cycles = 0;
    while (stall === 1'b1 && stall_cycles < 60) begin stall_cycles++; tick(1); end
    n_cmp++; if (stall_cycles !== 28) begin n_err++; $display("FAIL b2b_stall_cycles: got %0d expected 28", stall_cycles); end
    tick(1);            // second accepted
    io_req = 1'b0;
    get_seg(1, s);
    n_cmp++; if (s !== 7'h66) begin n_err++; $display("FAIL b2b_first_digit1: got %h expected 66", s); end
    get_seg(0, s);
    n_cmp++; if (s !== 7'h5B) begin n_err++; $display("FAIL b2b_first_digit0: got %h expected 5b", s); end
    tick(40);
    get_seg(0, s);
    n_cmp++; if (s !== 7'h07) begin n_err++; $display("FAIL b2b_second_digit0: got %h expected 07", s); end
    get_seg(1, s);
    n_cmp++; if (s !== 7'h00) begin n_err++; $display("FAIL b2b_second_digit1: got %h expected 00", s); end
    get_seg(7, s);
    n_cmp++; if (s !== 7'h00) begin n_err++; $display("FAIL b2b_second_sign: got %h expected 00", s); end
  endtask

  task automatic test_overflow();
    logic [6:0] s;
    io_req = 1'b1; io_op = 2'b10; io_wdata = 32'd10000000;
    tick(1); io_req = 1'b0; tick(40);
    for (int d = 0; d < 8; d++) begin
      get_seg(d, s);
      n_cmp++; if (s !== 7'h40) begin n_err++; $display("FAIL ovf_digit%0d: got %h expected 40", d, s); end
    end
    io_req = 1'b1; io_wdata = 32'd9999999;
    tick(1); io_req = 1'b0; tick(40);
    get_seg(6, s);
    n_cmp++; if (s !== 7'h6F) begin n_err++; $display("FAIL max_digit6: got %h expected 6f", s); end
    get_seg(7, s);
    n_cmp++; if (s !== 7'h00) begin n_err++; $display("FAIL max_sign: got %h expected 00", s); end
    io_req = 1'b1; io_wdata = 32'h80000000;
    tick(1); io_req = 1'b0; tick(40);
    get_seg(0, s);
    n_cmp++; if (s !== 7'h40) begin n_err++; $display("FAIL minneg_digit0: got %h expected 40", s); end
  endtask

  task automatic test_reset_mid_read();
    int seen;
    io_req = 1'b1; io_op = 2'b00;
    continue_button = 1'b1;
    tick(12);
    reset = 1'b0;
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL abort_stall: got %b expected 0", stall); end
    n_cmp++; if (io_rvalid !== 1'b0) begin n_err++; $display("FAIL abort_rvalid: got %b expected 0", io_rvalid); end
    n_cmp++; if (led !== 8'h00) begin n_err++; $display("FAIL abort_led: got %h expected 00", led); end
    continue_button = 1'b0;
    io_req = 1'b0;
    tick(2);
    reset = 1'b1;
    seen = 0;
    for (int c = 0; c < 20; c++) begin tick(1); if (io_rvalid === 1'b1) seen++; end
    n_cmp++; if (seen !== 0) begin n_err++; $display("FAIL abort_no_rvalid: got %0d expected 0", seen); end
  endtask

  initial begin
    test_reset();
    test_read();
    test_held_button();
    test_hex_led();
    test_decimal();
    test_back_to_back();
    test_overflow();
    test_reset_mid_read();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
